rst_seq: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 22 ++
 rtl/rst_seq_sync.sv | 24 ++
 rtl/rst_seq.sv | 141 ++++++++++++++
 tb/tb_rst_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the rst_seq reset sequencer.
package rst_seq_pkg;

    // Sequencer phases
    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        HOLD    = 2'd3
    } state_e;

    // Encodings reported on rst_cause
    localparam logic [1:0] CAUSE_EXT = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    // Larger of two integers, used to size the shared phase counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// rst_sync: two-flop synchronizer for the board reset.
// Reset asserts asynchronously (both flops cleared), and the release
// ripples through two flops so that the deassertion seen by the local
// logic is aligned to clk_i.
module rst_sync (
    input  logic clk_i,
    input  logic rst_i,
    output logic sync_o
);

    logic [1:0] sync_q;

    // Shift a constant 1 through the chain once the external reset drops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign sync_o = sync_q[1];

endmodule

// File: rtl/rst_seq.sv
// rst_seq: staged reset sequencer for one clock domain.
// The board reset asserts every stage asynchronously; release is
// synchronized, then the stages drop one at a time, STAGE_DELAY cycles
// apart, lowest bit first. In RUN, software (sw_rst_req) can re-reset
// the domain, holding all stages for SWRST_MIN cycles before the staged
// release runs again.
// Optional watchdog: define RST_SEQ_WDT_EN to enable it. Without that
// macro the wdt_kick input is accepted but ignored.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 256,
    parameter int SWRST_MIN   = 16,
    parameter int WDT_WIDTH   = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sw_rst_req,
    input  logic                  wdt_kick,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  rst_done,
    output logic [1:0]            rst_cause
);

    // One counter serves both the inter-stage gap and the software hold
    localparam int CNT_W = $clog2(max_int(STAGE_DELAY, SWRST_MIN)) + 1;
    localparam logic [CNT_W-1:0] SD_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] SM_LAST = CNT_W'(SWRST_MIN - 1);

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_STAGES-1:0] rst_out_q;
    logic [NUM_STAGES-1:0] stage_d;
    logic                  rst_done_q;
    logic [1:0]            cause_q;
    logic                  sync_rel;
    logic                  wdt_expire;

    rst_sync u_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .sync_o (sync_rel)
    );

    // Stages clear from bit 0 upward, so releasing the lowest asserted
    // bit is a left shift of the current mask.
    assign stage_d = rst_out_q << 1;

`ifdef RST_SEQ_WDT_EN
    localparam logic [WDT_WIDTH-1:0] WDT_LAST = {WDT_WIDTH{1'b1}} - WDT_WIDTH'(1);

    logic [WDT_WIDTH-1:0] wdt_q;
    logic [WDT_WIDTH-1:0] wdt_d;

    // Count only while in RUN; any other phase (including the entry edge) holds zero
    always_comb begin
        wdt_d = '0;
        if (state_q == RUN && !wdt_kick) begin
            wdt_d = wdt_q + WDT_WIDTH'(1);
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end

    // Expiry is the edge on which the counter reaches all ones; a kick wins
    assign wdt_expire = (state_q == RUN) && !wdt_kick && (wdt_q == WDT_LAST);
`else
    assign wdt_expire = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, wdt_kick, {WDT_WIDTH{1'b0}}};
`endif

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SYNC;
            cnt_q      <= '0;
            rst_out_q  <= '1;
            rst_done_q <= 1'b0;
            cause_q    <= CAUSE_EXT;
        end else begin
            case (state_q)
                SYNC: begin
                    if (sync_rel) begin
                        state_q <= RELEASE;
                        cnt_q   <= '0;
                    end
                end
                RELEASE: begin
                    if (cnt_q == SD_LAST) begin
                        cnt_q     <= '0;
                        rst_out_q <= stage_d;
                        if (stage_d == '0) begin
                            state_q    <= RUN;
                            rst_done_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (sw_rst_req || wdt_expire) begin
                        state_q    <= HOLD;
                        cnt_q      <= '0;
                        rst_out_q  <= '1;
                        rst_done_q <= 1'b0;
                        // Software takes priority when both fire together
                        cause_q    <= sw_rst_req ? CAUSE_SW : CAUSE_WDT;
                    end
                end
                HOLD: begin
                    // Domain stays clocked here, so no re-synchronization is needed
                    if (cnt_q == SM_LAST) begin
                        state_q <= RELEASE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= SYNC;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rst_out   = rst_out_q;
    assign rst_done  = rst_done_q;
    assign rst_cause = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with a schedule-based reference model.
module tb_rst_seq;

    localparam int NS   = 4;
    localparam int SD   = 8;
    localparam int SM   = 4;
    localparam int WW   = 6;
    localparam int WMAX = (1 << WW) - 1;
`ifdef RST_SEQ_WDT_EN
    localparam bit WDT = 1'b1;
`else
    localparam bit WDT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clk_en = 1'b1;
    logic          rst = 1'b0;
    logic          sw_rst_req = 1'b0;
    logic          wdt_kick = 1'b0;
    logic [NS-1:0] rst_out;
    logic          rst_done;
    logic [1:0]    rst_cause;

    int ecnt = 0;
    int org = 0;
    int n_checks = 0;
    int n_fail = 0;
    int e_sw = 0;
    int r_run = 0;
    int kq = 0;

    // Reference model: the release schedule is a base edge; stage i drops at
    // base+(i+1)*SD. Watchdog expiry is 63 edges after the last RUN entry or kick.
    bit         m_rst = 1'b1;
    int         m_n = 0;
    int         m_base = 0;
    int         m_wref = 0;
    logic [1:0] m_cause = 2'b00;
    bit         m_was_run;

    rst_seq #(
        .NUM_STAGES  (NS),
        .STAGE_DELAY (SD),
        .SWRST_MIN   (SM),
        .WDT_WIDTH   (WW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .wdt_kick   (wdt_kick),
        .rst_out    (rst_out),
        .rst_done   (rst_done),
        .rst_cause  (rst_cause)
    );

    always #5 if (clk_en) clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    function automatic int rel(input int x, input int b);
        int r;
        if (x < b) return 0;
        r = (x - b) / SD;
        return (r > NS) ? NS : r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rst   = 1'b1;
            m_cause = 2'b00;
        end else begin
            m_was_run = !m_rst && (rel(m_n, m_base) == NS);
            m_n = m_n + 1;
            if (m_rst) begin
                m_rst  = 1'b0;
                m_base = m_n + 2;
            end else if (m_was_run) begin
                if (sw_rst_req) begin
                    m_base  = m_n + SM;
                    m_cause = 2'b01;
                end else if (WDT && !wdt_kick && (m_n - m_wref) == WMAX) begin
                    m_base  = m_n + SM;
                    m_cause = 2'b10;
                end else if (wdt_kick) begin
                    m_wref = m_n;
                end
            end
            if (!m_was_run && !m_rst && rel(m_n, m_base) == NS) m_wref = m_n;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [NS-1:0] eo;
        int r;
        r  = rel(m_n, m_base);
        eo = '1;
        if (!m_rst) begin
            for (int i = 0; i < NS; i++) if (i < r) eo[i] = 1'b0;
        end
        chk("model rst_out", 32'(rst_out), 32'(eo));
        chk("model rst_done", 32'(rst_done), 32'(!m_rst && r == NS));
        chk("model rst_cause", 32'(rst_cause), 32'(m_cause));
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    // Advance to the negedge following relative edge j
    task automatic go(input int j);
        int lim = 0;
        while (ecnt < org + j + 1 && lim < 2000) begin
            tick();
            lim++;
        end
        if (lim >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout waiting for edge %0d", j);
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) tick();
        chk("reset rst_out", 32'(rst_out), 32'h0000_000f);
        chk("reset rst_done", 32'(rst_done), 32'h0);
        chk("reset rst_cause", 32'(rst_cause), 32'h0);

        // External release, edge 0 is the next posedge
        rst = 1'b0;
        org = ecnt;
        go(9);  chk("s1 e9 out", 32'(rst_out), 32'hf);
        go(10); chk("s1 e10 out", 32'(rst_out), 32'he);
        go(17); chk("s1 e17 out", 32'(rst_out), 32'he);
        go(18); chk("s1 e18 out", 32'(rst_out), 32'hc);
        go(26); chk("s1 e26 out", 32'(rst_out), 32'h8);
        go(33); chk("s1 e33 done", 32'(rst_done), 32'h0);
        go(34); chk("s1 e34 out", 32'(rst_out), 32'h0);
        chk("s1 e34 done", 32'(rst_done), 32'h1);
        chk("s1 e34 cause", 32'(rst_cause), 32'h0);

        // Restart, then reassert rst mid-release with the clock stopped
        rst = 1'b1;
        tick();
        rst = 1'b0;
        org = ecnt;
        go(20); chk("s2 e20 out", 32'(rst_out), 32'hc);
        clk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("s2 async out", 32'(rst_out), 32'hf);
        chk("s2 async done", 32'(rst_done), 32'h0);
        check_model();
        #1 rst = 1'b0;
        org = ecnt;
        clk_en = 1'b1;
        go(10); chk("s2 e10 out", 32'(rst_out), 32'he);
        // Software request during RELEASE is ignored
        go(13);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        go(18); chk("s4 e18 out", 32'(rst_out), 32'hc);
        go(34); chk("s2 e34 out", 32'(rst_out), 32'h0);
        chk("s4 e34 done", 32'(rst_done), 32'h1);
        chk("s4 e34 cause", 32'(rst_cause), 32'h0);

        // Software reset from RUN
        sw_rst_req = 1'b1;
        e_sw = ecnt - org;
        tick();
        sw_rst_req = 1'b0;
        chk("s3 e out", 32'(rst_out), 32'hf);
        chk("s3 e done", 32'(rst_done), 32'h0);
        chk("s3 e cause", 32'(rst_cause), 32'h1);
        go(e_sw + 11); chk("s3 e+11 out", 32'(rst_out), 32'hf);
        go(e_sw + 12); chk("s3 e+12 out", 32'(rst_out), 32'he);
        go(e_sw + 35); chk("s3 e+35 done", 32'(rst_done), 32'h0);
        go(e_sw + 36); chk("s3 e+36 done", 32'(rst_done), 32'h1);
        chk("s3 e+36 out", 32'(rst_out), 32'h0);
        r_run = e_sw + 36;

`ifdef RST_SEQ_WDT_EN
        go(r_run + 62); chk("s5 r+62 done", 32'(rst_done), 32'h1);
        go(r_run + 63); chk("s5 r+63 out", 32'(rst_out), 32'hf);
        chk("s5 r+63 cause", 32'(rst_cause), 32'h2);
        go(r_run + 99); chk("s5 r+99 done", 32'(rst_done), 32'h1);
        for (int i = 0; i < 4; i++) begin
            repeat (49) tick();
            wdt_kick = 1'b1;
            kq = ecnt - org;
            tick();
            wdt_kick = 1'b0;
        end
        chk("s5 kicked done", 32'(rst_done), 32'h1);
        chk("s5 kicked cause", 32'(rst_cause), 32'h2);
        // Software request lands on the expiry edge
        go(kq + 62);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk("s6 tie out", 32'(rst_out), 32'hf);
        chk("s6 tie cause", 32'(rst_cause), 32'h1);
        go(kq + 63 + 36); chk("s6 resumed done", 32'(rst_done), 32'h1);
        chk("s6 resumed cause", 32'(rst_cause), 32'h1);
`else
        repeat (200) tick();
        chk("s6 nowdt done", 32'(rst_done), 32'h1);
        chk("s6 nowdt cause", 32'(rst_cause), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
